l1_icache_param: RTL and testbench
==================================

Name: l1_icache_param

Overview:
Parametrised direct-mapped, read-only L1 instruction cache sitting between the CPU fetch port (port 1) and main memory's line-refill interface. It replaces the fixed 128-bit-block L1 with configurable line size, line count and data width. It adds a ready/valid fetch handshake, an explicit refill request/ack handshake, a single-cycle flush, and saturating hit/miss counters.

Parameters:
ADDR_W, 32, byte-address width
DATA_W, 32, fetch word width (must be 32 or 64)
WORDS_PER_LINE, 4, words per line, power of 2, >=2
NUM_LINES, 16, number of cache lines, power of 2, >=2
CNT_W, 16, width of the hit and miss counters

Ports:
MEM_CLK  in  1  clock; all logic on the rising edge
RST  in  1  reset, synchronous, active-low
MEM_READ1  in  1  fetch request
MEM_ADDR1  in  ADDR_W  fetch byte address; low log2(DATA_W/8) bits ignored
MEM_READY1  out  1  cache can accept a request this cycle
MEM_DOUT1  out  DATA_W  fetched word
MEM_VALID1  out  1  one-cycle pulse: MEM_DOUT1 valid
FLUSH  in  1  invalidate all lines
REFILL_REQ  out  1  line refill request to main memory
REFILL_ADDR  out  ADDR_W  line-aligned refill byte address
REFILL_ACK  in  1  one-cycle pulse: REFILL_BLOCK valid
REFILL_BLOCK  in  DATA_W*WORDS_PER_LINE  line data; word 0 in bits [DATA_W-1:0]
HIT_CNT  out  CNT_W  accepted hits
MISS_CNT  out  CNT_W  accepted misses

Behaviour:
- Address split, from LSB up: byte offset log2(DATA_W/8) bits; word offset log2(WORDS_PER_LINE) bits; index log2(NUM_LINES) bits; tag is the remainder.
- Storage per line: valid bit, tag, and data. Data is register-based; a read must be combinational on the index.
- Reset (RST=0 at an edge):
  - State goes to IDLE and all valid bits clear.
  - MEM_DOUT1=0, MEM_VALID1=0, REFILL_REQ=0, REFILL_ADDR=0, HIT_CNT=0, MISS_CNT=0.
  - MEM_READY1=0 while RST=0.
  - Reset wins over every other input, including mid-refill. A REFILL_ACK arriving after reset is ignored.
- MEM_READY1 = (state==IDLE) && !FLUSH, combinational.
- A request is accepted at an edge where MEM_READ1 && MEM_READY1.
- FSM states: IDLE, MISS, RESP.
- IDLE, accepted hit (line valid and tag match):
  - Next edge: MEM_DOUT1 = selected word, MEM_VALID1=1, HIT_CNT += 1. State stays IDLE.
  - Hits are fully pipelined: one hit per cycle, latency 1 cycle.
- IDLE, accepted miss:
  - Latch the address; MISS_CNT += 1; MEM_VALID1=0.
  - Go to MISS with REFILL_REQ=1 and REFILL_ADDR = latched address with word and byte offsets zeroed.
- MISS:
  - Hold REFILL_REQ and REFILL_ADDR stable until an edge with REFILL_ACK=1.
  - On that edge: write REFILL_BLOCK into the indexed line, set tag and valid, drop REFILL_REQ, register the requested word into MEM_DOUT1, go to RESP.
  - REFILL_ACK while not in MISS is ignored.
- RESP: MEM_VALID1=1 for this single cycle, then return to IDLE. Miss latency = ack edge + 1 cycle.
- MEM_VALID1 is 0 in every cycle not listed above. MEM_DOUT1 holds its last value.
- FLUSH (level) clears all valid bits at the edge and blocks acceptance in that cycle.
- FLUSH during MISS still clears all valid bits. The outstanding refill still completes, installs its line as valid, and responds.
- FLUSH on the same edge as the refill install: the install wins for that line; all other lines clear.
- Counters saturate at 2^CNT_W-1 and never wrap. MEM_READ1 while MEM_READY1=0 does not count.
- MEM_ADDR1 need not be held after acceptance.

Test Plan:
Defaults throughout: DATA_W=32, WORDS_PER_LINE=4, NUM_LINES=16, so index = ADDR[7:4] and tag = ADDR[31:8].
- Cold miss: read 0x0000_0104 -> next cycle MEM_READY1=0, REFILL_REQ=1, REFILL_ADDR=0x0000_0100. Ack 3 cycles later with block {0x4444_4444, 0x3333_3333, 0x2222_2222, 0x1111_1111} -> one cycle after the ack edge, MEM_VALID1=1 with MEM_DOUT1=0x2222_2222, and MISS_CNT=1.
- Back-to-back hits: reads 0x100, 0x108, 0x10C on consecutive cycles -> MEM_VALID1 high for 3 consecutive cycles, each one cycle after its request, with DOUT 0x1111_1111, 0x3333_3333, 0x4444_4444; HIT_CNT=3; REFILL_REQ stays 0.
- Conflict eviction: read 0x0000_1100 (index 0, new tag) -> REFILL_ADDR=0x0000_1100. After its fill, read 0x100 -> miss again; MISS_CNT=3.
- Flush: line 0 valid; FLUSH=1 with MEM_READ1=1 at 0x100 -> MEM_READY1=0, no count, no VALID. Next cycle read 0x100 -> REFILL_REQ=1.
- Reset mid-refill: RST=0 for one edge while REFILL_REQ=1, then ack the next cycle -> REFILL_REQ=0 after the reset edge, no MEM_VALID1, counters 0, a later read 0x100 misses.
- Saturation: CNT_W=2, fill one line, then 5 hits -> HIT_CNT reads 1, 2, 3, 3, 3.

Source files
------------

// File: rtl/l1_icache_param.sv
// Direct-mapped, read-only L1 instruction cache with ready/valid fetch, line refill handshake,
// single-cycle flush and saturating hit/miss counters.
module l1_icache_param #(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned WORDS_PER_LINE = 4,
    parameter int unsigned NUM_LINES      = 16,
    parameter int unsigned CNT_W          = 16
) (
    input  logic                             MEM_CLK,
    input  logic                             RST,
    input  logic                             MEM_READ1,
    input  logic [ADDR_W-1:0]                MEM_ADDR1,
    output logic                             MEM_READY1,
    output logic [DATA_W-1:0]                MEM_DOUT1,
    output logic                             MEM_VALID1,
    input  logic                             FLUSH,
    output logic                             REFILL_REQ,
    output logic [ADDR_W-1:0]                REFILL_ADDR,
    input  logic                             REFILL_ACK,
    input  logic [DATA_W*WORDS_PER_LINE-1:0] REFILL_BLOCK,
    output logic [CNT_W-1:0]                 HIT_CNT,
    output logic [CNT_W-1:0]                 MISS_CNT
);

    localparam int unsigned BYTE_W = $clog2(DATA_W / 8);
    localparam int unsigned WORD_W = $clog2(WORDS_PER_LINE);
    localparam int unsigned IDX_W  = $clog2(NUM_LINES);
    localparam int unsigned OFF_W  = BYTE_W + WORD_W;
    localparam int unsigned TAG_W  = ADDR_W - OFF_W - IDX_W;

    typedef logic [WORDS_PER_LINE-1:0][DATA_W-1:0] line_t;
    typedef enum logic [1:0] {StIdle, StMiss, StResp} state_e;

    state_e state_q, state_d;

    logic [NUM_LINES-1:0] valid_q;
    logic [TAG_W-1:0]     tag_q [NUM_LINES];
    line_t                data_q [NUM_LINES];

    logic [ADDR_W-1:0] refill_addr_q, refill_addr_d;
    logic              refill_req_q, refill_req_d;
    logic [WORD_W-1:0] miss_word_q, miss_word_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              valid_out_q, valid_out_d;
    logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]  miss_cnt_q, miss_cnt_d;

    logic [IDX_W-1:0]  req_idx, fill_idx;
    logic [TAG_W-1:0]  req_tag, fill_tag;
    logic [WORD_W-1:0] req_word;
    line_t             rd_line, fill_line;
    logic              hit, ready, accept, install;
    logic              unused_byte_bits;

    assign req_word  = MEM_ADDR1[BYTE_W +: WORD_W];
    assign req_idx   = MEM_ADDR1[OFF_W +: IDX_W];
    assign req_tag   = MEM_ADDR1[ADDR_W-1 -: TAG_W];
    assign fill_idx  = refill_addr_q[OFF_W +: IDX_W];
    assign fill_tag  = refill_addr_q[ADDR_W-1 -: TAG_W];
    assign fill_line = REFILL_BLOCK;
    assign rd_line   = data_q[req_idx];

    assign unused_byte_bits = ^MEM_ADDR1[BYTE_W-1:0];

    assign hit    = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign ready  = RST && (state_q == StIdle) && !FLUSH;
    assign accept = MEM_READ1 && ready;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    always_comb begin
        state_d       = state_q;
        refill_addr_d = refill_addr_q;
        refill_req_d  = refill_req_q;
        miss_word_d   = miss_word_q;
        dout_d        = dout_q;
        valid_out_d   = 1'b0;
        hit_cnt_d     = hit_cnt_q;
        miss_cnt_d    = miss_cnt_q;
        install       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (hit) begin
                        dout_d      = rd_line[req_word];
                        valid_out_d = 1'b1;
                        hit_cnt_d   = sat_inc(hit_cnt_q);
                    end else begin
                        state_d       = StMiss;
                        refill_req_d  = 1'b1;
                        refill_addr_d = {MEM_ADDR1[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        miss_word_d   = req_word;
                        miss_cnt_d    = sat_inc(miss_cnt_q);
                    end
                end
            end
            StMiss: begin
                if (REFILL_ACK) begin
                    install      = 1'b1;
                    refill_req_d = 1'b0;
                    dout_d       = fill_line[miss_word_q];
                    valid_out_d  = 1'b1;
                    state_d      = StResp;
                end
            end
            StResp: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge MEM_CLK) begin
        if (!RST) begin
            state_q       <= StIdle;
            valid_q       <= '0;
            refill_addr_q <= '0;
            refill_req_q  <= 1'b0;
            miss_word_q   <= '0;
            dout_q        <= '0;
            valid_out_q   <= 1'b0;
            hit_cnt_q     <= '0;
            miss_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            refill_addr_q <= refill_addr_d;
            refill_req_q  <= refill_req_d;
            miss_word_q   <= miss_word_d;
            dout_q        <= dout_d;
            valid_out_q   <= valid_out_d;
            hit_cnt_q     <= hit_cnt_d;
            miss_cnt_q    <= miss_cnt_d;
            // Flush clears first so a same-edge install keeps its line valid.
            if (FLUSH) valid_q <= '0;
            if (install) valid_q[fill_idx] <= 1'b1;
        end
    end

    always_ff @(posedge MEM_CLK) begin
        if (RST && install) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= fill_line;
        end
    end

    assign MEM_READY1  = ready;
    assign MEM_DOUT1   = dout_q;
    assign MEM_VALID1  = valid_out_q;
    assign REFILL_REQ  = refill_req_q;
    assign REFILL_ADDR = refill_addr_q;
    assign HIT_CNT     = hit_cnt_q;
    assign MISS_CNT    = miss_cnt_q;

endmodule

// File: tb/tb_l1_icache_param.sv
// Bench for l1_icache_param: directed scenarios with literal expectations, then random traffic
// checked every cycle against an array-based cache model. Two instances share stimulus.
module tb_l1_icache_param;

    logic         clk = 1'b0;
    logic         rst_n, rd, flush, ack;
    logic [31:0]  addr;
    logic [127:0] blk;

    logic         ready_a, valid_a, req_a, ready_b, valid_b, req_b;
    logic [31:0]  dout_a, raddr_a, dout_b, raddr_b;
    logic [15:0]  hit_a, miss_a;
    logic [1:0]   hit_b, miss_b;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    l1_icache_param #(.ADDR_W(32), .DATA_W(32), .WORDS_PER_LINE(4), .NUM_LINES(16), .CNT_W(16))
    u_dut (
        .MEM_CLK(clk), .RST(rst_n), .MEM_READ1(rd), .MEM_ADDR1(addr), .MEM_READY1(ready_a),
        .MEM_DOUT1(dout_a), .MEM_VALID1(valid_a), .FLUSH(flush), .REFILL_REQ(req_a),
        .REFILL_ADDR(raddr_a), .REFILL_ACK(ack), .REFILL_BLOCK(blk), .HIT_CNT(hit_a),
        .MISS_CNT(miss_a)
    );

    l1_icache_param #(.ADDR_W(32), .DATA_W(32), .WORDS_PER_LINE(4), .NUM_LINES(16), .CNT_W(2))
    u_dut_sat (
        .MEM_CLK(clk), .RST(rst_n), .MEM_READ1(rd), .MEM_ADDR1(addr), .MEM_READY1(ready_b),
        .MEM_DOUT1(dout_b), .MEM_VALID1(valid_b), .FLUSH(flush), .REFILL_REQ(req_b),
        .REFILL_ADDR(raddr_b), .REFILL_ACK(ack), .REFILL_BLOCK(blk), .HIT_CNT(hit_b),
        .MISS_CNT(miss_b)
    );

    // Reference model: cache contents plus the observable outputs after the latest edge.
    bit          m_valid [16];
    logic [23:0] m_tag [16];
    logic [31:0] m_data [16][4];
    bit          m_busy, m_resp;
    int          m_word;
    logic [31:0] e_dout, e_raddr;
    bit          e_valid, e_req;
    int unsigned m_hits, m_misses;

    function automatic int unsigned sat(input int unsigned v, input int unsigned max);
        return (v > max) ? max : v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_valid[i] = 0;
        m_busy = 0; m_resp = 0; m_word = 0;
        e_dout = 0; e_raddr = 0; e_valid = 0; e_req = 0;
        m_hits = 0; m_misses = 0;
    endtask

    task automatic model_edge();
        int idx, word, li;
        bit rdy;
        idx = int'(addr[7:4]);
        word = int'(addr[3:2]);
        if (!rst_n) begin
            model_reset();
        end else begin
            rdy = !m_busy && !m_resp && !flush;
            e_valid = 0;
            if (flush) for (int i = 0; i < 16; i++) m_valid[i] = 0;
            if (m_busy && ack) begin
                li = int'(e_raddr[7:4]);
                m_valid[li] = 1;
                m_tag[li] = e_raddr[31:8];
                for (int w = 0; w < 4; w++) m_data[li][w] = blk[w*32 +: 32];
                e_dout = m_data[li][m_word];
                e_valid = 1; e_req = 0; m_busy = 0; m_resp = 1;
            end else if (m_resp) begin
                m_resp = 0;
            end else if (rd && rdy) begin
                if (m_valid[idx] && m_tag[idx] == addr[31:8]) begin
                    e_dout = m_data[idx][word];
                    e_valid = 1;
                    m_hits++;
                end else begin
                    m_misses++;
                    m_busy = 1; e_req = 1;
                    e_raddr = {addr[31:4], 4'h0};
                    m_word = word;
                end
            end
        end
    endtask

    task automatic compare_all();
        bit e_ready;
        e_ready = rst_n && !m_busy && !m_resp && !flush;
        check("ready", ready_a, e_ready);
        check("ready_sat", ready_b, e_ready);
        check("valid", valid_a, e_valid);
        check("valid_sat", valid_b, e_valid);
        check("dout", dout_a, e_dout);
        check("dout_sat", dout_b, e_dout);
        check("refill_req", req_a, e_req);
        check("refill_req_sat", req_b, e_req);
        check("refill_addr", raddr_a, e_raddr);
        check("refill_addr_sat", raddr_b, e_raddr);
        check("hit_cnt", hit_a, sat(m_hits, 65535));
        check("hit_cnt_sat", hit_b, sat(m_hits, 3));
        check("miss_cnt", miss_a, sat(m_misses, 65535));
        check("miss_cnt_sat", miss_b, sat(m_misses, 3));
    endtask

    task automatic step(input bit r, input bit d, input logic [31:0] a, input bit f, input bit k,
                        input logic [127:0] b);
        @(negedge clk);
        rst_n = r; rd = d; addr = a; flush = f; ack = k; blk = b;
        #1;
        compare_all();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1, 0, 32'h0, 0, 0, 128'h0);
    endtask

    localparam logic [127:0] B1 = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
    localparam logic [127:0] B2 = 128'h8888_8888_7777_7777_6666_6666_5555_5555;

    initial begin
        int waited;
        int exp_sat [5];
        logic [23:0] t;
        logic [31:0] a;
        bit r, f, d, k;

        exp_sat[0] = 1; exp_sat[1] = 2; exp_sat[2] = 3; exp_sat[3] = 3; exp_sat[4] = 3;
        rst_n = 0; rd = 0; addr = 0; flush = 0; ack = 0; blk = 0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check("reset_dout", dout_a, 32'h0);
        check("reset_valid", valid_a, 1'b0);
        check("reset_req", req_a, 1'b0);
        check("reset_raddr", raddr_a, 32'h0);
        check("reset_hit", hit_a, 16'h0);
        check("reset_miss", miss_a, 16'h0);
        check("reset_ready", ready_a, 1'b0);

        // Cold miss
        step(1, 1, 32'h104, 0, 0, 128'h0);
        check("cold_ready", ready_a, 1'b0);
        check("cold_req", req_a, 1'b1);
        check("cold_raddr", raddr_a, 32'h100);
        idle(); idle();
        step(1, 0, 32'h0, 0, 1, B1);
        check("cold_valid", valid_a, 1'b1);
        check("cold_dout", dout_a, 32'h2222_2222);
        check("cold_miss", miss_a, 16'd1);
        idle();

        // Back-to-back hits
        step(1, 1, 32'h100, 0, 0, 128'h0);
        check("hit0_valid", valid_a, 1'b1);
        check("hit0_dout", dout_a, 32'h1111_1111);
        step(1, 1, 32'h108, 0, 0, 128'h0);
        check("hit1_valid", valid_a, 1'b1);
        check("hit1_dout", dout_a, 32'h3333_3333);
        step(1, 1, 32'h10C, 0, 0, 128'h0);
        check("hit2_valid", valid_a, 1'b1);
        check("hit2_dout", dout_a, 32'h4444_4444);
        check("hit_count", hit_a, 16'd3);
        check("hit_no_req", req_a, 1'b0);

        // Conflict eviction
        step(1, 1, 32'h1100, 0, 0, 128'h0);
        check("evict_req", req_a, 1'b1);
        check("evict_raddr", raddr_a, 32'h1100);
        step(1, 0, 32'h0, 0, 1, B2);
        idle();
        step(1, 1, 32'h100, 0, 0, 128'h0);
        check("evict_req2", req_a, 1'b1);
        check("evict_miss", miss_a, 16'd3);
        step(1, 0, 32'h0, 0, 1, B1);
        idle();

        // Flush blocks acceptance and invalidates
        step(1, 1, 32'h100, 1, 0, 128'h0);
        check("flush_ready", ready_a, 1'b0);
        check("flush_valid", valid_a, 1'b0);
        check("flush_hit", hit_a, 16'd3);
        step(1, 1, 32'h100, 0, 0, 128'h0);
        check("flush_req", req_a, 1'b1);
        step(1, 0, 32'h0, 0, 1, B1);
        idle();

        // Reset mid-refill, late ack ignored
        step(1, 1, 32'h1100, 0, 0, 128'h0);
        check("rst_pre_req", req_a, 1'b1);
        step(0, 0, 32'h0, 0, 0, 128'h0);
        check("rst_req", req_a, 1'b0);
        check("rst_hit", hit_a, 16'd0);
        check("rst_miss", miss_a, 16'd0);
        step(1, 0, 32'h0, 0, 1, B2);
        check("rst_ack_valid", valid_a, 1'b0);
        step(1, 1, 32'h100, 0, 0, 128'h0);
        check("rst_remiss", req_a, 1'b1);
        step(1, 0, 32'h0, 0, 1, B1);
        idle();

        // Counter saturation on the narrow instance
        for (int i = 0; i < 5; i++) begin
            step(1, 1, 32'h100, 0, 0, 128'h0);
            check("sat_hit", hit_b, exp_sat[i]);
        end
        idle();

        // Random traffic
        waited = 0;
        for (int n = 0; n < 3000; n++) begin
            r = ($urandom_range(0, 199) != 0);
            f = ($urandom_range(0, 24) == 0);
            d = ($urandom_range(0, 9) < 7);
            case ($urandom_range(0, 2))
                0: t = 24'h000001;
                1: t = 24'h000011;
                default: t = 24'hABCDEF;
            endcase
            a = {t, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
            if (m_busy) begin
                k = ($urandom_range(0, 2) == 0) || (waited > 8);
                waited = k ? 0 : waited + 1;
            end else begin
                k = ($urandom_range(0, 9) == 0);
                waited = 0;
            end
            step(r, d, a, f, k, {$urandom, $urandom, $urandom, $urandom});
        end
        step(1, 0, 32'h0, 0, 1, 128'h0);
        idle(); idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
